// File: rtl/piece_move_gen.sv
// Sequential pseudo-legal destination generator for a single chess piece.
// Latches the board on start, then examines one candidate square per cycle.
module piece_move_gen #(
  parameter int N           = 8,
  parameter int CODE_W      = 4,
  parameter bit PAWN_DOUBLE = 1'b1,
  localparam int IDX_W      = $clog2(N)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [CODE_W-1:0]                  selected_figure,
  input  logic [N-1:0][N-1:0][CODE_W-1:0]    board,
  input  logic [2*IDX_W-1:0]                 position,
  output logic                               busy,
  output logic                               done,
  output logic                               moves_valid,
  output logic [N*N-1:0]                     possible_moves
);

  localparam int CW = IDX_W + 2;
  localparam int MW = $clog2(N*N);
  localparam logic [CW-1:0] ZR = {CW{1'b0}};
  localparam logic [CW-1:0] P1 = CW'(1);
  localparam logic [CW-1:0] P2 = CW'(2);
  localparam logic [CW-1:0] M1 = {CW{1'b1}};
  localparam logic [CW-1:0] M2 = {{(CW-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PAWN  = 3'd2,
    JUMP  = 3'd3,
    SLIDE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                            state_r, state_n;
  logic [N-1:0][N-1:0][CODE_W-1:0]   board_r;
  logic [CODE_W-1:0]                 fig_r;
  logic [IDX_W-1:0]                  row_r, col_r;
  logic [2:0]                        step_r, step_n;
  logic [CW-1:0]                     ray_row_r, ray_col_r, ray_row_n, ray_col_n;
  logic                              fwd_empty_r, fwd_empty_n;
  logic [N*N-1:0]                    mask_r, mask_n;
  logic                              busy_r, busy_n, done_r, done_n, valid_r, valid_n;

  logic                              lat_s, set_s, white_s, on_s, empty_s, own_s, enemy_s;
  logic                              start_row_s;
  logic [2:0]                        cls_s, last_s;
  logic [2*CW-1:0]                   offs_s;
  logic [CW-1:0]                     pos_row_s, pos_col_s, base_r_s, base_c_s, tr_s, tc_s;
  logic [IDX_W-1:0]                  tr_idx_s, tc_idx_s;
  logic [CODE_W-1:0]                 sq_s;
  logic [MW-1:0]                     bit_s;

  // Offsets are packed {drow, dcol}; negative steps are two's complement in CW bits.
  function automatic logic [2*CW-1:0] pawn_off(input logic white, input logic [2:0] k);
    logic [CW-1:0] d1, d2;
    d1 = white ? M1 : P1;
    d2 = white ? M2 : P2;
    case (k)
      3'd0:    pawn_off = {d1, ZR};
      3'd1:    pawn_off = {d2, ZR};
      3'd2:    pawn_off = {d1, M1};
      3'd3:    pawn_off = {d1, P1};
      default: pawn_off = {ZR, ZR};
    endcase
  endfunction

  function automatic logic [2*CW-1:0] jump_off(input logic knight, input logic [2:0] k);
    if (knight) begin
      case (k)
        3'd0:    jump_off = {M2, M1};
        3'd1:    jump_off = {M2, P1};
        3'd2:    jump_off = {M1, M2};
        3'd3:    jump_off = {M1, P2};
        3'd4:    jump_off = {P1, M2};
        3'd5:    jump_off = {P1, P2};
        3'd6:    jump_off = {P2, M1};
        default: jump_off = {P2, P1};
      endcase
    end else begin
      case (k)
        3'd0:    jump_off = {M1, M1};
        3'd1:    jump_off = {M1, ZR};
        3'd2:    jump_off = {M1, P1};
        3'd3:    jump_off = {ZR, M1};
        3'd4:    jump_off = {ZR, P1};
        3'd5:    jump_off = {P1, M1};
        3'd6:    jump_off = {P1, ZR};
        default: jump_off = {P1, P1};
      endcase
    end
  endfunction

  function automatic logic [2*CW-1:0] slide_off(input logic [2:0] k);
    case (k)
      3'd0:    slide_off = {M1, ZR};
      3'd1:    slide_off = {P1, ZR};
      3'd2:    slide_off = {ZR, M1};
      3'd3:    slide_off = {ZR, P1};
      3'd4:    slide_off = {M1, M1};
      3'd5:    slide_off = {M1, P1};
      3'd6:    slide_off = {P1, M1};
      default: slide_off = {P1, P1};
    endcase
  endfunction

  assign pos_row_s   = CW'(row_r);
  assign pos_col_s   = CW'(col_r);
  assign start_row_s = white_s ? (row_r == IDX_W'(N-2)) : (row_r == IDX_W'(1));
  assign last_s      = (cls_s == 3'd4) ? 3'd3 : 3'd7;

  // Piece class (1=P..6=K, 0=invalid) and colour of the latched figure.
  always_comb begin
    cls_s   = 3'd0;
    white_s = 1'b0;
    if (fig_r == CODE_W'(0)) begin
      cls_s = 3'd0;
    end else if (fig_r <= CODE_W'(6)) begin
      cls_s   = fig_r[2:0];
      white_s = 1'b1;
    end else if (fig_r <= CODE_W'(12)) begin
      cls_s = 3'(fig_r - CODE_W'(6));
    end else begin
      cls_s = 3'd0;
    end
  end

  // Candidate square for this cycle and what it holds.
  always_comb begin
    offs_s   = '0;
    base_r_s = pos_row_s;
    base_c_s = pos_col_s;
    case (state_r)
      PAWN:  offs_s = pawn_off(white_s, step_r);
      JUMP:  offs_s = jump_off(cls_s == 3'd2, step_r);
      SLIDE: begin
        offs_s   = slide_off(step_r);
        base_r_s = ray_row_r;
        base_c_s = ray_col_r;
      end
      default: offs_s = '0;
    endcase
    tr_s     = base_r_s + offs_s[2*CW-1:CW];
    tc_s     = base_c_s + offs_s[CW-1:0];
    on_s     = !tr_s[CW-1] && (tr_s[CW-2:0] <= (CW-1)'(N-1)) &&
               !tc_s[CW-1] && (tc_s[CW-2:0] <= (CW-1)'(N-1));
    tr_idx_s = tr_s[IDX_W-1:0];
    tc_idx_s = tc_s[IDX_W-1:0];
    sq_s     = on_s ? board_r[tr_idx_s][tc_idx_s] : CODE_W'(0);
    empty_s  = (sq_s == CODE_W'(0));
    own_s    = white_s ? ((sq_s >= CODE_W'(1)) && (sq_s <= CODE_W'(6)))
                       : ((sq_s >= CODE_W'(7)) && (sq_s <= CODE_W'(12)));
    enemy_s  = !empty_s && !own_s;
    bit_s    = MW'(N*N-1) - (MW'(tr_idx_s) * MW'(N) + MW'(tc_idx_s));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state_r;
    step_n      = step_r;
    ray_row_n   = ray_row_r;
    ray_col_n   = ray_col_r;
    fwd_empty_n = fwd_empty_r;
    mask_n      = mask_r;
    busy_n      = busy_r;
    done_n      = 1'b0;
    valid_n     = valid_r;
    lat_s       = 1'b0;
    set_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n = LOAD;
          lat_s   = 1'b1;
          busy_n  = 1'b1;
          valid_n = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        mask_n      = '0;
        fwd_empty_n = 1'b0;
        ray_row_n   = pos_row_s;
        ray_col_n   = pos_col_s;
        step_n      = 3'd0;
        case (cls_s)
          3'd1:       state_n = PAWN;
          3'd2, 3'd6: state_n = JUMP;
          3'd3: begin
            state_n = SLIDE;
            step_n  = 3'd4;
          end
          3'd4, 3'd5: state_n = SLIDE;
          default:    state_n = DONE;
        endcase
      end
      PAWN: begin
        case (step_r)
          3'd0: begin
            set_s       = on_s && empty_s;
            fwd_empty_n = on_s && empty_s;
          end
          3'd1:    set_s = PAWN_DOUBLE && start_row_s && fwd_empty_r && on_s && empty_s;
          default: set_s = on_s && enemy_s;
        endcase
        if (step_r == 3'd3) begin
          state_n = DONE;
        end else begin
          step_n = step_r + 3'd1;
        end
      end
      JUMP: begin
        set_s = on_s && !own_s;
        if (step_r == 3'd7) begin
          state_n = DONE;
        end else begin
          step_n = step_r + 3'd1;
        end
      end
      SLIDE: begin
        if (on_s && empty_s) begin
          set_s     = 1'b1;
          ray_row_n = tr_s;
          ray_col_n = tc_s;
        end else begin
          // Ray ends here; an enemy square is still a capture.
          set_s     = on_s && enemy_s;
          ray_row_n = pos_row_s;
          ray_col_n = pos_col_s;
          if (step_r == last_s) begin
            state_n = DONE;
          end else begin
            step_n = step_r + 3'd1;
          end
        end
      end
      DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        valid_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (set_s) begin
      mask_n[bit_s] = 1'b1;
    end else begin
      mask_n = mask_n;
    end
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      board_r     <= '0;
      fig_r       <= '0;
      row_r       <= '0;
      col_r       <= '0;
      step_r      <= 3'd0;
      ray_row_r   <= '0;
      ray_col_r   <= '0;
      fwd_empty_r <= 1'b0;
      mask_r      <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      valid_r     <= 1'b0;
    end else begin
      state_r     <= state_n;
      step_r      <= step_n;
      ray_row_r   <= ray_row_n;
      ray_col_r   <= ray_col_n;
      fwd_empty_r <= fwd_empty_n;
      mask_r      <= mask_n;
      busy_r      <= busy_n;
      done_r      <= done_n;
      valid_r     <= valid_n;
      if (lat_s) begin
        board_r <= board;
        fig_r   <= selected_figure;
        row_r   <= position[2*IDX_W-1:IDX_W];
        col_r   <= position[IDX_W-1:0];
      end
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign moves_valid    = valid_r;
  assign possible_moves = mask_r;

endmodule
